// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle for the 4-way round-robin channel arbiter.
// The master drives requests and per-requester data; the slave returns the grant and the muxed channel.
interface mux_rr_arbiter_if;
    logic [3:0] req;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] c;
    logic [1:0] d;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] x;
    logic       valid;

    modport master (
        output req, a, b, c, d,
        input  gnt, sel, x, valid
    );

    modport slave (
        input  req, a, b, c, d,
        output gnt, sel, x, valid
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time, driving a shared 2-bit channel.
// The grant and index are registered; the channel data is muxed combinationally from the registered index.
module mux_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   bus
);

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic                others_req;
    logic                grant_new;
    logic [1:0]          x_c;

    // First requester at or after the pointer; scanning backwards leaves the nearest one as winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (bus.req[ptr_q + IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + IDX_W'(k);
            end
        end
    end

    assign others_req = |(bus.req & ~gnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; the pointer always sits just past the owner, so a preempted owner scans last.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        grant_new = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_new = 1'b1;
                end
            end
            BUSY: begin
                if (bus.req[sel_q]) begin
                    if (hold_q < HOLD_LAST) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end else if (others_req) begin
                        grant_new = 1'b1;
                    end
                end else if (win_found) begin
                    grant_new = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (grant_new) begin
            state_d = BUSY;
            gnt_d   = N_REQ'(1) << win_idx;
            sel_d   = win_idx;
            ptr_d   = win_idx + IDX_W'(1);
            hold_d  = '0;
        end
    end

    always_comb begin
        x_c = '0;
        if (state_q == BUSY) begin
            case (sel_q)
                2'd0:    x_c = bus.a;
                2'd1:    x_c = bus.b;
                2'd2:    x_c = bus.c;
                default: x_c = bus.d;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = (state_q == BUSY);
    assign bus.x     = x_c;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic against an integer-level
// model of the round-robin rules (owner, pointer and hold count tracked as plain ints).
module tb_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst_n;
    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: owner is -1 when nobody holds the channel.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int  win;
        bit  take;
        win  = -1;
        take = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (win < 0 && r[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        end
        if (m_owner < 0) begin
            take = (win >= 0);
        end else if (r[m_owner]) begin
            if (m_hold < MAX_HOLD - 1) m_hold++;
            else if ((r & ~(4'b0001 << m_owner)) != 4'b0000) take = 1'b1;
        end else if (win >= 0) begin
            take = 1'b1;
        end else begin
            m_owner = -1;
        end
        if (take) begin
            m_owner = win;
            m_sel   = win;
            m_ptr   = (win + 1) % 4;
            m_hold  = 0;
        end
    endtask

    function automatic logic [1:0] data_of(input int idx);
        case (idx)
            0:       return bus.a;
            1:       return bus.b;
            2:       return bus.c;
            default: return bus.d;
        endcase
    endfunction

    task automatic compare_model();
        logic [3:0] exp_gnt;
        logic [1:0] exp_x;
        exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        exp_x   = (m_owner < 0) ? 2'b00 : data_of(m_owner);
        check("model_gnt",   32'(bus.gnt),   32'(exp_gnt));
        check("model_sel",   32'(bus.sel),   32'(m_sel));
        check("model_valid", 32'(bus.valid), 32'(m_owner >= 0));
        check("model_x",     32'(bus.x),     32'(exp_x));
    endtask

    // Entered at a negedge: apply request, clock once, then compare at the following negedge.
    task automatic drive_cycle(input logic [3:0] r);
        bus.req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_gnt",   32'(bus.gnt),   32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_x",     32'(bus.x),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        bus.req = 4'b0000;
        bus.a = 2'b00; bus.b = 2'b00; bus.c = 2'b00; bus.d = 2'b00;
        model_reset();

        // Requests and data all high while reset is held: nothing may be granted.
        bus.req = 4'b1111;
        bus.a = 2'b11; bus.b = 2'b11; bus.c = 2'b11; bus.d = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check("hold_rst_gnt",   32'(bus.gnt),   32'h0);
            check("hold_rst_valid", 32'(bus.valid), 32'h0);
            check("hold_rst_x",     32'(bus.x),     32'h0);
        end
        rst_n = 1'b1;
        drive_cycle(4'b1111);
        check("first_grant", 32'(bus.gnt), 32'b0001);

        // Single request from C.
        do_reset();
        bus.c = 2'b10;
        drive_cycle(4'b0100);
        check("c_gnt",   32'(bus.gnt),   32'b0100);
        check("c_sel",   32'(bus.sel),   32'd2);
        check("c_valid", 32'(bus.valid), 32'd1);
        check("c_x",     32'(bus.x),     32'b10);

        // All requesting: each holds MAX_HOLD cycles in rotation.
        do_reset();
        bus.a = 2'd0; bus.b = 2'd1; bus.c = 2'd2; bus.d = 2'd3;
        for (int i = 0; i < 4 * MAX_HOLD + 1; i++) begin
            drive_cycle(4'b1111);
            check("rr_seq", 32'(bus.gnt), 32'(4'b0001 << ((i / MAX_HOLD) % 4)));
        end

        // Owner drops with another pending: direct handover.
        do_reset();
        drive_cycle(4'b0111);
        check("drop_own", 32'(bus.gnt), 32'b0001);
        drive_cycle(4'b0110);
        check("drop_gnt",   32'(bus.gnt),   32'b0010);
        check("drop_valid", 32'(bus.valid), 32'd1);

        // Lone requester keeps grant past MAX_HOLD, then releases to IDLE.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(4'b0010);
            check("lone_gnt", 32'(bus.gnt), 32'b0010);
        end
        drive_cycle(4'b0000);
        check("lone_idle_gnt",   32'(bus.gnt),   32'h0);
        check("lone_idle_valid", 32'(bus.valid), 32'h0);
        check("lone_idle_x",     32'(bus.x),     32'h0);

        // Reset pulsed between edges while D holds the grant.
        do_reset();
        drive_cycle(4'b1000);
        check("d_gnt", 32'(bus.gnt), 32'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt",   32'(bus.gnt),   32'h0);
        check("mid_rst_valid", 32'(bus.valid), 32'h0);
        check("mid_rst_x",     32'(bus.x),     32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(4'b1111);
        check("ptr_restart", 32'(bus.gnt), 32'b0001);

        // Randomized traffic: requests tend to persist so holds and preemptions occur.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 4'($urandom_range(0, 15));
                1:       r = r ^ (4'b0001 << $urandom_range(0, 3));
                default: r = r;
            endcase
            bus.a = 2'($urandom_range(0, 3));
            bus.b = 2'($urandom_range(0, 3));
            bus.c = 2'($urandom_range(0, 3));
            bus.d = 2'($urandom_range(0, 3));
            drive_cycle(r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, is the maximum number of consecutive cycles one requester keeps the grant while others wait (legal range 2..255).
REQ-002 CLK  input  1  the single clock; all state is updated on its rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 REQ  input  4  request lines; bit i belongs to requester i (0=A, 1=B, 2=C, 3=D), level-sensitive.
REQ-005 A  input  2  requester 0 data.
REQ-006 B  input  2  requester 1 data.
REQ-007 C  input  2  requester 2 data.
REQ-008 D  input  2  requester 3 data.
REQ-009 GNT  output  4  one-hot grant (registered); all-zero when nobody is granted.
REQ-010 SEL  output  2  registered binary index of the granted requester.
REQ-011 X  output  2  shared channel output: data of the requester selected by SEL.
REQ-012 VALID  output  1  high while a grant is active.

Function
REQ-013 FSM states: IDLE and BUSY; VALID SHALL be 1 exactly in BUSY.
REQ-014 In BUSY, X SHALL equal the current A/B/C/D input indexed by SEL (combinational from registered SEL); in IDLE, X SHALL be 2'b00.
REQ-015 GNT SHALL be one-hot in BUSY, all-zero in IDLE, and SEL SHALL equal the index of the set GNT bit.
REQ-016 Round-robin pointer PTR (2 bits): the winner SHALL be the first requester with REQ set, scanning PTR, PTR+1, ... mod 4.
REQ-017 On every new grant to requester i, PTR SHALL become (i+1) mod 4 and the hold counter SHALL clear to 0.
REQ-018 IDLE with REQ!=0 at edge n: BUSY with the winner granted after edge n (one-cycle request-to-grant latency).
REQ-019 IDLE with REQ==0: remain IDLE; GNT, SEL, PTR unchanged.
REQ-020 BUSY, owner i, REQ[i]=1, hold count < MAX_HOLD-1: keep the grant; the hold counter increments.
REQ-021 BUSY, owner i, REQ[i]=1, hold count == MAX_HOLD-1, other REQ bits set: preempt; grant the next winner from PTR at that edge.
REQ-022 BUSY, owner i, REQ[i]=1, hold count == MAX_HOLD-1, no other request: keep the grant; the hold counter saturates at MAX_HOLD-1.
REQ-023 BUSY, owner i, REQ[i]=0, other requests pending: switch directly to the next winner at that edge (no idle gap).
REQ-024 BUSY, owner i, REQ[i]=0, no other request: go to IDLE; GNT=0000, SEL holds its last value.
REQ-025 A requester re-raising REQ in the same cycle it is preempted SHALL NOT regain the grant before all other pending requesters have been served once.
REQ-026 Hold counter width SHALL be 8 bits and SHALL never wrap.

Reset
REQ-027 RST_N=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, GNT=0000, SEL=00, VALID=0, X=00, PTR=0, hold counter=0.
REQ-028 Reset asserted mid-grant SHALL abort the grant with no completion cycle.
REQ-029 After RST_N rises, the first possible grant SHALL be issued at the first rising CLK edge with REQ!=0.

Verification
REQ-030 RST_N=0, REQ=1111, A..D=11 -> GNT=0000, VALID=0, X=00 throughout; the first edge after release grants GNT=0001.
REQ-031 IDLE, REQ=0100, C=10 set before edge n -> after edge n: GNT=0100, SEL=10, VALID=1, X=10.
REQ-032 MAX_HOLD=4, REQ=1111 held constant -> GNT sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, then 0001.
REQ-033 Owner 0 holding, REQ changes 0111->0110 -> next edge GNT=0010, with no IDLE cycle in between.
REQ-034 MAX_HOLD=4, only REQ=0010 held for 10 cycles -> GNT=0010 for all 10 cycles; REQ->0000 -> next edge IDLE, VALID=0, X=00.
REQ-035 BUSY with GNT=1000, RST_N pulsed low between edges -> GNT=0000, VALID=0 immediately; PTR restarts at 0.
